// File: rtl/bcd_sum_display_if.sv
// Operand/result capture bus and multiplexed seven-segment display lines
// for the BCD adder display stage.
interface bcd_sum_display_if;
  logic       load;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] sum;
  logic       co;
  logic [3:0] an;
  logic [6:0] seg;

  modport master (output load, a, b, sum, co, input an, seg);
  modport slave  (input load, a, b, sum, co, output an, seg);
endinterface

// File: rtl/bcd_sum_display.sv
// Latches A, B and the BCD adder result, then time-multiplexes them onto a
// 4-digit common-anode seven-segment display, one digit per DIV-cycle slot.
module bcd_sum_display #(
  parameter int unsigned DIV = 50000,
  parameter int unsigned CW  = 20
) (
  input logic              clk,
  input logic              rst,
  bcd_sum_display_if.slave bus
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [6:0]    SEG_BLANK = 7'b1111111;
  localparam logic [6:0]    SEG_E     = 7'b0000110;

  // Digit slots, encoded so the value is the an[] bit position it enables.
  typedef enum logic [1:0] {
    SLOT_ONES = 2'd0,
    SLOT_TENS = 2'd1,
    SLOT_B    = 2'd2,
    SLOT_A    = 2'd3
  } slot_t;

  slot_t         idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    a_q, a_d;
  logic [3:0]    b_q, b_d;
  logic [3:0]    sum_q, sum_d;
  logic          co_q, co_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          tick_c;

  // Active-low gfedcba pattern for a BCD code; anything above 9 shows "E".
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= SLOT_A;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      co_q  <= 1'b0;
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      a_q   <= a_d;
      b_q   <= b_d;
      sum_q <= sum_d;
      co_q  <= co_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  // Next-state: divider, capture, and slot advance on tick. The digit
  // content is decoded from the pre-edge latches, so a load coinciding
  // with a tick is only visible from that digit's next slot.
  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    idx_d  = idx_q;
    a_d    = a_q;
    b_d    = b_q;
    sum_d  = sum_q;
    co_d   = co_q;
    an_d   = an_q;
    seg_d  = seg_q;
    tick_c = (cnt_q == CNT_LAST);

    if (bus.load) begin
      a_d   = bus.a;
      b_d   = bus.b;
      sum_d = bus.sum;
      co_d  = bus.co;
    end

    if (tick_c) begin
      cnt_d = '0;
      idx_d = slot_t'(2'(idx_q + 2'd1));
      an_d  = ~(4'b0001 << idx_d);
      case (idx_d)
        SLOT_A:    seg_d = decode(a_q);
        SLOT_B:    seg_d = decode(b_q);
        SLOT_TENS: seg_d = co_q ? decode(4'd1) : SEG_BLANK;
        SLOT_ONES: seg_d = decode(sum_q);
        default:   seg_d = SEG_BLANK;
      endcase
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;

endmodule

// File: doc/bcd_sum_display.md
Name: bcd_sum_display

Overview:
- Downstream stage of the one-digit BCD adder. Captures the adder operands (A, B) and its result (C, co) on a load strobe.
- Drives a 4-digit, common-anode, multiplexed seven-segment display with one digit enabled at a time.
- Each digit is refreshed in turn at a rate set by a clock-divider parameter.
- Illegal BCD codes (>9) are shown as "E"; the tens digit is blanked when there is no carry.

Parameters:
- DIV, 50000, clock cycles per digit slot (refresh tick period); legal range 2..2^20-1.
- CW, 20, width of the divider counter; must satisfy 2^CW > DIV.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- load  in  1  capture strobe; samples a, b, sum, co on this edge.
- a  in  4  BCD operand A.
- b  in  4  BCD operand B.
- sum  in  4  adder ones digit (C); 4'b1111 marks illegal input.
- co  in  1  adder carry (tens digit).
- an  out  4  digit enables, active-low; an[3]=A, an[2]=B, an[1]=tens, an[0]=ones.
- seg  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}.

Behaviour:
- Reset: rst=1 on a rising edge sets the following; reset mid-scan or mid-load aborts immediately, and a load in the same cycle as rst is ignored.
  - an=4'b1111 and seg=7'b1111111.
  - Divider counter = 0 and digit index idx = 3.
  - Latched a_q, b_q, sum_q = 0 and co_q = 0.
- Capture:
  - On an edge with load=1 (rst=0), a_q/b_q/sum_q/co_q take the input values.
  - load=0 holds the latched values; inputs are otherwise ignored.
- Divider:
  - The counter increments each cycle. When it equals DIV-1 it wraps to 0 and asserts an internal tick for that edge.
- Scan on tick edge:
  - idx <= idx+1, wrapping 3 -> 0.
  - an <= one-hot-low for the new idx.
  - seg <= decode(new digit) from the latched values as they were before that edge.
  - If load and tick coincide, the old latched value is shown; the new value appears from the next tick whose slot selects that digit.
- Outputs are fully registered; an and seg change only on tick edges or reset.
  - First tick after reset: at cycle DIV after reset release, an=4'b1110 (ones digit).
- Digit content:
  - idx 3: a_q.
  - idx 2: b_q.
  - idx 1: "1" if co_q=1, else blank.
  - idx 0: sum_q.
- Illegal code handling:
  - Any a_q, b_q or sum_q value > 9 displays "E" (0000110).
  - When sum_q = 4'b1111 and co_q = 0, the tens digit is blank and the ones digit shows "E".
- Decode table (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - E=0000110, blank=1111111.
- Refresh period: 4*DIV cycles per full display frame.
- No combinational path from inputs to outputs.

Test Plan:
- Reset check (DIV=4): assert rst for 2 cycles and release -> an=1111, seg=1111111 for cycles 0..3; at cycle 4 an=1110, seg=1000000 (ones digit "0").
- Normal sum (DIV=4): load a=7, b=8, sum=5, co=1 -> over one frame:
  - an=1110 with seg=0010010 ("5").
  - an=1101 with seg=1111001 ("1").
  - an=1011 with seg=0000000 ("8").
  - an=0111 with seg=1111000 ("7").
  - Each digit is held for exactly 4 cycles.
- No carry: load a=2, b=3, sum=5, co=0 -> tens slot (an=1101) shows seg=1111111; ones slot shows 0010010.
- Illegal input: load a=12, b=3, sum=1111, co=0 -> ones slot shows E 0000110, tens slot blank, A slot shows E, B slot shows "3" 0110000.
- Simultaneous load and tick: assert load on the edge where the divider is at DIV-1 for the ones slot -> that slot shows the old sum; the new sum appears on the next ones slot, 4*DIV cycles later.
- Reset mid-scan: assert rst while an=1011 -> next edge an=1111, seg=1111111, latched values cleared; after release the first tick selects the ones digit and shows "0".
